player_motion_ctrl: RTL and testbench



---
 rtl/player_motion_pkg.sv | 38 +++
 rtl/player_motion_ctrl_vert.sv | 67 ++++++
 rtl/player_motion_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/player_motion_pkg.sv
// Shared definitions for the player motion controller: keycodes, motion
// states, screen geometry and a small saturation helper.
package player_motion_pkg;

    // Decoded keycodes produced by the keyboard stage
    localparam logic [3:0] KEY_RIGHT      = 4'h4;
    localparam logic [3:0] KEY_LEFT       = 4'h2;
    localparam logic [3:0] KEY_JUMP       = 4'h1;
    localparam logic [3:0] KEY_JUMP_RIGHT = 4'h5;
    localparam logic [3:0] KEY_JUMP_LEFT  = 4'h3;

    // Screen and sprite geometry in pixels
    localparam int SCREEN_W = 640;
    localparam int PLAYER_W = 44;
    localparam int PLAYER_H = 72;

    typedef enum logic [1:0] {
        GROUNDED  = 2'd0,
        JUMP_RISE = 2'd1,
        JUMP_FALL = 2'd2
    } motion_state_t;

    // Clamp a signed 11-bit coordinate into the unsigned range [lo, hi]
    function automatic logic [9:0] sat_u10(input logic signed [10:0] v,
                                           input logic [9:0]         lo,
                                           input logic [9:0]         hi);
        logic [9:0] r;
        if (v < $signed({1'b0, lo})) begin
            r = lo;
        end else if (v > $signed({1'b0, hi})) begin
            r = hi;
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/player_motion_ctrl_vert.sv
// player_vert_integrator: one-frame vertical step for an airborne player.
// Applies velocity to Y, adds gravity with a fall-speed cap, detects landing
// on the floor and the apex (velocity no longer upward) while rising.
import player_motion_pkg::*;

module player_vert_integrator #(
    parameter logic [9:0] GROUND_Y = 10'd300,
    parameter logic [5:0] GRAVITY  = 6'd1,
    parameter logic [5:0] MAX_FALL = 6'd12
) (
    input  motion_state_t state,
    input  logic [9:0]    y,
    input  logic [5:0]    vel,
    output logic [9:0]    y_next,
    output logic [5:0]    vel_next,
    output logic          land,
    output logic          apex
);

    logic signed [10:0] y_sum_s;
    logic signed [6:0]  vel_sum_s;
    logic [5:0]         vel_cap_s;

    assign y_sum_s   = $signed({1'b0, y}) + $signed({{5{vel[5]}}, vel});
    assign vel_sum_s = $signed({vel[5], vel}) + $signed({1'b0, GRAVITY});

    // Gravity step with the downward speed capped at MAX_FALL
    always_comb begin
        vel_cap_s = vel_sum_s[5:0];
        if (vel_sum_s > $signed({1'b0, MAX_FALL})) begin
            vel_cap_s = MAX_FALL;
        end else begin
            vel_cap_s = vel_sum_s[5:0];
        end
    end

    // Position/velocity update, landing snap and ceiling saturation
    always_comb begin
        y_next   = y;
        vel_next = vel;
        land     = 1'b0;
        apex     = 1'b0;
        case (state)
            JUMP_RISE, JUMP_FALL: begin
                if ((state == JUMP_FALL) && (y_sum_s >= $signed({1'b0, GROUND_Y}))) begin
                    land     = 1'b1;
                    y_next   = GROUND_Y;
                    vel_next = 6'd0;
                end else if (y_sum_s < 11'sd0) begin
                    y_next   = 10'd0;
                    vel_next = 6'd0;
                end else begin
                    y_next   = y_sum_s[9:0];
                    vel_next = vel_cap_s;
                end
                apex = (state == JUMP_RISE) && !vel_next[5];
            end
            default: begin
                y_next   = y;
                vel_next = vel;
                land     = 1'b0;
                apex     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame player kinematics (run, jump, gravity, clamp).
// One frame_Clk edge is one video frame; all outputs are registered.
// Optional macro PLAYER_MOTION_AIR_CONTROL_EN: when defined, run keys steer
// the player while airborne; otherwise the horizontal step is latched at
// takeoff and the facing direction is frozen until landing.
import player_motion_pkg::*;

module player_motion_ctrl #(
    parameter logic [9:0] INIT_X   = 10'd64,
    parameter logic [9:0] GROUND_Y = 10'd300,
    parameter logic [9:0] X_MIN    = 10'd0,
    parameter logic [9:0] X_MAX    = 10'(SCREEN_W - PLAYER_W - 1),
    parameter logic [3:0] RUN_STEP = 4'd2,
    parameter logic [5:0] JUMP_VEL = 6'd12,
    parameter logic [5:0] GRAVITY  = 6'd1,
    parameter logic [5:0] MAX_FALL = 6'd12
) (
    input  logic       frame_Clk,
    input  logic       Reset,
    input  logic [3:0] keycode,
    output logic [9:0] PlayerX,
    output logic [9:0] PlayerY,
    output logic       moving,
    output logic       playerDirection,
    output logic       frameCounter_0,
    output logic       airborne
);

    motion_state_t state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [5:0]    vel_q, vel_d;
    logic          dir_q, dir_d;
    logic          moving_q, moving_d;
    logic [3:0]    fc_q, fc_d;
    logic          airborne_q, airborne_d;
    logic          jump_prev_q, jump_prev_d;

    logic          run_r_s, run_l_s, jump_k_s, jump_rise_s;
    logic          step_r_s, step_l_s, dir_en_s;
    logic signed [10:0] x_sum_s;
    logic [9:0]    y_int_s;
    logic [5:0]    vel_int_s;
    logic          land_s, apex_s;

    assign run_r_s     = (keycode == KEY_RIGHT) || (keycode == KEY_JUMP_RIGHT);
    assign run_l_s     = (keycode == KEY_LEFT)  || (keycode == KEY_JUMP_LEFT);
    assign jump_k_s    = (keycode == KEY_JUMP)  || (keycode == KEY_JUMP_LEFT) ||
                         (keycode == KEY_JUMP_RIGHT);
    assign jump_rise_s = jump_k_s && !jump_prev_q;

    player_vert_integrator #(
        .GROUND_Y (GROUND_Y),
        .GRAVITY  (GRAVITY),
        .MAX_FALL (MAX_FALL)
    ) u_vert (
        .state    (state_q),
        .y        (y_q),
        .vel      (vel_q),
        .y_next   (y_int_s),
        .vel_next (vel_int_s),
        .land     (land_s),
        .apex     (apex_s)
    );

`ifdef PLAYER_MOTION_AIR_CONTROL_EN
    // Run keys steer and turn the player in every state
    always_comb begin
        step_r_s = run_r_s;
        step_l_s = run_l_s;
        dir_en_s = 1'b1;
    end
`else
    logic air_r_q, air_r_d;
    logic air_l_q, air_l_d;

    // On the ground follow the keys; in the air replay the takeoff step
    always_comb begin
        air_r_d = air_r_q;
        air_l_d = air_l_q;
        if (state_q == GROUNDED) begin
            step_r_s = run_r_s;
            step_l_s = run_l_s;
            dir_en_s = 1'b1;
            air_r_d  = run_r_s;
            air_l_d  = run_l_s;
        end else begin
            step_r_s = air_r_q;
            step_l_s = air_l_q;
            dir_en_s = 1'b0;
        end
    end

    // Latched takeoff step direction
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            air_r_q <= 1'b0;
            air_l_q <= 1'b0;
        end else begin
            air_r_q <= air_r_d;
            air_l_q <= air_l_d;
        end
    end
`endif

    // Horizontal step in signed 11 bits so moving left from 0 cannot wrap
    always_comb begin
        if (step_r_s) begin
            x_sum_s = $signed({1'b0, x_q}) + $signed({7'd0, RUN_STEP});
        end else if (step_l_s) begin
            x_sum_s = $signed({1'b0, x_q}) - $signed({7'd0, RUN_STEP});
        end else begin
            x_sum_s = $signed({1'b0, x_q});
        end
    end

    // Next-state logic: jump FSM, clamped X, facing, counters
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        vel_d       = vel_q;
        case (state_q)
            GROUNDED: begin
                if (jump_rise_s) begin
                    state_d = JUMP_RISE;
                    vel_d   = 6'd0 - JUMP_VEL;
                end else begin
                    state_d = GROUNDED;
                end
            end
            JUMP_RISE: begin
                y_d   = y_int_s;
                vel_d = vel_int_s;
                if (apex_s) begin
                    state_d = JUMP_FALL;
                end else begin
                    state_d = JUMP_RISE;
                end
            end
            JUMP_FALL: begin
                y_d   = y_int_s;
                vel_d = vel_int_s;
                if (land_s) begin
                    state_d = GROUNDED;
                end else begin
                    state_d = JUMP_FALL;
                end
            end
            default: begin
                state_d = GROUNDED;
                y_d     = GROUND_Y;
                vel_d   = 6'd0;
            end
        endcase

        x_d = sat_u10(x_sum_s, X_MIN, X_MAX);

        if (dir_en_s && run_l_s) begin
            dir_d = 1'b1;
        end else if (dir_en_s && run_r_s) begin
            dir_d = 1'b0;
        end else begin
            dir_d = dir_q;
        end

        moving_d    = (state_d == GROUNDED) && (run_r_s || run_l_s);
        airborne_d  = (state_d != GROUNDED);
        fc_d        = fc_q + 4'd1;
        jump_prev_d = jump_k_s;
    end

    // Frame-rate state registers with synchronous reset
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            state_q     <= GROUNDED;
            x_q         <= INIT_X;
            y_q         <= GROUND_Y;
            vel_q       <= 6'd0;
            dir_q       <= 1'b0;
            moving_q    <= 1'b0;
            fc_q        <= 4'd0;
            airborne_q  <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            dir_q       <= dir_d;
            moving_q    <= moving_d;
            fc_q        <= fc_d;
            airborne_q  <= airborne_d;
            jump_prev_q <= jump_prev_d;
        end
    end

    assign PlayerX         = x_q;
    assign PlayerY         = y_q;
    assign moving          = moving_q;
    assign playerDirection = dir_q;
    assign frameCounter_0  = fc_q[0];
    assign airborne        = airborne_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: directed frames push their
// hand-computed expected outputs; a monitor pops and compares each frame.
module tb_player_motion_ctrl;

    logic       frame_Clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [3:0] keycode   = 4'h0;
    logic [9:0] PlayerX, PlayerY;
    logic       moving, playerDirection, frameCounter_0, airborne;

    always #5 frame_Clk = ~frame_Clk;

    player_motion_ctrl dut (
        .frame_Clk       (frame_Clk),
        .Reset           (Reset),
        .keycode         (keycode),
        .PlayerX         (PlayerX),
        .PlayerY         (PlayerY),
        .moving          (moving),
        .playerDirection (playerDirection),
        .frameCounter_0  (frameCounter_0),
        .airborne        (airborne)
    );

    // mask bits: 0 X, 1 Y, 2 moving, 3 direction, 4 airborne, 5 frameCounter_0
    localparam logic [5:0] ALL   = 6'h3F;
    localparam logic [5:0] NO_MV = 6'h3B;

    typedef struct {
        int         cyc;
        string      name;
        int         x;
        int         y;
        int         mv;
        int         dir;
        int         air;
        int         fc;
        logic [5:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   since_rst = 0;

    // Jump trajectory t1..t25 from takeoff: -12 up, +1 gravity per frame
    int ytab [25] = '{288, 277, 267, 258, 250, 243, 237, 232, 228, 225, 223, 222,
                      222, 223, 225, 228, 232, 237, 243, 250, 258, 267, 277, 288, 300};

    always @(posedge frame_Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, expv);
        end
    endtask

    // Drive one frame of input and queue the outputs expected after its edge
    task automatic frame(input logic [3:0] key, input logic rst, input string nm,
                         input int x, input int y, input int mv, input int dir,
                         input int air, input logic [5:0] mask);
        exp_t e;
        @(negedge frame_Clk);
        keycode   = key;
        Reset     = rst;
        since_rst = rst ? 0 : since_rst + 1;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.x    = x;
        e.y    = y;
        e.mv   = mv;
        e.dir  = dir;
        e.air  = air;
        e.fc   = since_rst % 2;
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    // Monitor: each frame, compare outputs with every expectation due now
    always @(negedge frame_Clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                chk({e.name, " stale"}, cyc, e.cyc);
            end else begin
                if (e.mask[0]) chk({e.name, " X"},   int'(PlayerX), e.x);
                if (e.mask[1]) chk({e.name, " Y"},   int'(PlayerY), e.y);
                if (e.mask[2]) chk({e.name, " mv"},  int'(moving), e.mv);
                if (e.mask[3]) chk({e.name, " dir"}, int'(playerDirection), e.dir);
                if (e.mask[4]) chk({e.name, " air"}, int'(airborne), e.air);
                if (e.mask[5]) chk({e.name, " fc0"}, int'(frameCounter_0), e.fc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ax, adir, xl;
        // Reset state and idle frames
        frame(4'h0, 1'b1, "rst", 64, 300, 0, 0, 0, ALL);
        frame(4'h0, 1'b1, "rst", 64, 300, 0, 0, 0, ALL);
        for (int k = 1; k <= 4; k++) frame(4'h0, 1'b0, "idle", 64, 300, 0, 0, 0, ALL);

        // Run right 10 frames then one frame left
        for (int k = 1; k <= 10; k++) frame(4'h4, 1'b0, "run_r", 64 + 2 * k, 300, 1, 0, 0, ALL);
        frame(4'h2, 1'b0, "turn_l", 82, 300, 1, 1, 0, ALL);

        // Left wall clamp, no wrap, moving stays high
        frame(4'h0, 1'b1, "rst3", 64, 300, 0, 0, 0, ALL);
        for (int k = 1; k <= 40; k++) begin
            xl = 64 - 2 * k;
            if (xl < 0) xl = 0;
            frame(4'h2, 1'b0, "clamp_l", xl, 300, 1, 1, 0, ALL);
        end

        // Single tap jump: full trajectory and landing
        frame(4'h0, 1'b1, "rst4", 64, 300, 0, 0, 0, ALL);
        frame(4'h1, 1'b0, "takeoff", 64, 300, 0, 0, 1, ALL);
        for (int k = 1; k <= 25; k++) frame(4'h0, 1'b0, "jump", 64, ytab[k-1], 0, 0, (k < 25) ? 1 : 0, ALL);
        frame(4'h0, 1'b0, "landed", 64, 300, 0, 0, 0, ALL);

        // Held jump key: exactly one jump, re-jump only after release
        frame(4'h1, 1'b0, "hold_takeoff", 64, 300, 0, 0, 1, ALL);
        for (int k = 1; k <= 39; k++)
            frame(4'h1, 1'b0, "hold", 64, (k <= 25) ? ytab[k-1] : 300, 0, 0, (k < 25) ? 1 : 0, ALL);
        frame(4'h0, 1'b0, "release", 64, 300, 0, 0, 0, ALL);
        frame(4'h1, 1'b0, "repress", 64, 300, 0, 0, 1, ALL);
        frame(4'h0, 1'b0, "repress_t1", 64, 288, 0, 0, 1, ALL);

        // Reset asserted at t6 of a jump
        frame(4'h0, 1'b1, "rst6", 64, 300, 0, 0, 0, ALL);
        frame(4'h1, 1'b0, "takeoff6", 64, 300, 0, 0, 1, ALL);
        for (int k = 1; k <= 5; k++) frame(4'h0, 1'b0, "jump6", 64, ytab[k-1], 0, 0, 1, ALL);
        frame(4'h0, 1'b1, "rst_mid", 64, 300, 0, 0, 0, ALL);
        for (int k = 1; k <= 3; k++) frame(4'h0, 1'b0, "post_rst", 64, 300, 0, 0, 0, ALL);

        // Jump+right takeoff, then left key held in the air
        frame(4'h5, 1'b0, "air_takeoff", 66, 300, 0, 0, 1, NO_MV);
        for (int k = 1; k <= 25; k++) begin
`ifdef PLAYER_MOTION_AIR_CONTROL_EN
            ax = 66 - 2 * k; adir = 1;
`else
            ax = 66 + 2 * k; adir = 0;
`endif
            frame(4'h2, 1'b0, "air_steer", ax, ytab[k-1], 0, adir, (k < 25) ? 1 : 0,
                  (k < 25) ? ALL : NO_MV);
        end
`ifdef PLAYER_MOTION_AIR_CONTROL_EN
        frame(4'h2, 1'b0, "landed_turn", 14, 300, 1, 1, 0, ALL);
`else
        frame(4'h2, 1'b0, "landed_turn", 114, 300, 1, 1, 0, ALL);
`endif

        repeat (3) @(negedge frame_Clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
